// File: rtl/ysyx_23060077_riscv_mem_arbiter.sv
// rtl/ysyx_23060077_riscv_mem_arbiter.sv - IFU/LSU arbiter and sequencer for the single core memory port
module ysyx_23060077_riscv_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy,
    output logic                err
);
    localparam int MASK_W = DATA_W / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;      // 1 = LSU owns the transaction
    logic [3:0]          starve_q, starve_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;

    logic force_ifu;
    logic lsu_win;
    logic ifu_win;
    logic resp_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            starve_q    <= '0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            err_q       <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            err_q       <= err_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        starve_d       = starve_q;
        addr_d         = addr_q;
        wen_d          = wen_q;
        wdata_d        = wdata_q;
        wmask_d        = wmask_q;
        err_d          = err_q;
        ifu_rdata_d    = ifu_rdata_q;
        lsu_rdata_d    = lsu_rdata_q;
        force_ifu      = 1'b0;
        lsu_win        = 1'b0;
        ifu_win        = 1'b0;
        resp_fire      = 1'b0;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                // Readies are gated by reset so every output reads 0 while rst_n is low.
                force_ifu     = ifu_req_valid && (starve_q == LIMIT);
                lsu_win       = rst_n && lsu_req_valid && !force_ifu;
                ifu_win       = rst_n && ifu_req_valid && !lsu_win;
                lsu_req_ready = lsu_win;
                ifu_req_ready = ifu_win;
                if (lsu_win) begin
                    owner_d  = 1'b1;
                    addr_d   = lsu_addr;
                    wen_d    = lsu_wen;
                    wdata_d  = lsu_wdata;
                    wmask_d  = lsu_wmask;
                    state_d  = REQ;
                    if (ifu_req_valid) begin
                        starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
                    end else begin
                        starve_d = '0;
                    end
                end else if (ifu_win) begin
                    owner_d  = 1'b0;
                    addr_d   = ifu_addr;
                    wen_d    = 1'b0;
                    wdata_d  = '0;
                    wmask_d  = '0;
                    starve_d = '0;
                    state_d  = REQ;
                end
                if (mem_resp_valid) begin
                    err_d = 1'b1;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    // A response coincident with acceptance completes the transaction.
                    if (mem_resp_valid) begin
                        resp_fire = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d   = RESP;
                    end
                end else if (mem_resp_valid) begin
                    err_d = 1'b1;
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    resp_fire = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (resp_fire) begin
            if (owner_q) begin
                lsu_resp_valid = 1'b1;
                lsu_rdata_d    = mem_rdata;
            end else begin
                ifu_resp_valid = 1'b1;
                ifu_rdata_d    = mem_rdata;
            end
        end
    end

    assign ifu_rdata = ifu_rdata_d;
    assign lsu_rdata = lsu_rdata_d;
    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule

// File: doc/ysyx_23060077_riscv_mem_arbiter.md
Name: ysyx_23060077_riscv_mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single core memory port.
- Shares that port between the instruction-fetch path (IFU, read-only) and the load/store path (LSU, read/write).
- Grants one transaction at a time, with one outstanding access max. Routes the response to its owner.
- LSU has fixed priority; a starvation counter guarantees IFU forward progress.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (wmask width = DATA_W/8)
- STARVE_LIMIT, 4, consecutive LSU grants while IFU is waiting before IFU is forced to win (range 1..15)

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  fetch data valid, 1-cycle pulse
- ifu_rdata  out  DATA_W  fetched instruction
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte enables
- lsu_resp_valid  out  1  load data / store done, 1-cycle pulse
- lsu_rdata  out  DATA_W  load data (don't-care for stores)
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  as LSU  registered request fields
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE
- err  out  1  sticky: mem_resp_valid seen outside RESP; cleared only by reset

Behaviour:
- Reset value: every output is 0; state = IDLE; owner = IFU; starve_cnt = 0.
- Reset mid-operation: the in-flight transaction is dropped silently and no resp pulse is issued.
- FSM states: IDLE, REQ, RESP.
- IDLE, arbitration (combinational):
  - winner = LSU if lsu_req_valid and not (ifu_req_valid and starve_cnt == STARVE_LIMIT); else IFU if ifu_req_valid.
  - The winner's req_ready = 1 in the same cycle; the loser's req_ready = 0.
  - req_ready outputs are 0 in every state other than IDLE.
- On handshake:
  - Latch owner, addr, wen, wdata, wmask; IFU grants force wen = 0, wmask = 0.
  - Go to REQ.
- starve_cnt update on handshake:
  - LSU grant with ifu_req_valid high: increment, saturating at STARVE_LIMIT.
  - IFU grant, or LSU grant with IFU idle: clear to 0.
- REQ:
  - mem_req_valid = 1; fields are held stable until mem_req_ready.
  - On mem_req_ready, go to RESP.
  - If mem_resp_valid arrives in the same cycle as mem_req_ready, treat it as completion: deliver the response and go to IDLE.
- RESP:
  - Wait for mem_resp_valid. There is no timeout.
  - On mem_resp_valid: owner's resp_valid = 1 and owner's rdata = mem_rdata, combinational in that cycle; go to IDLE.
  - The non-owner's resp_valid stays 0; rdata outputs hold their last value.
- mem_resp_valid in IDLE or in REQ (without mem_req_ready) is ignored and sets err.
- Minimum latency: accept at cycle T, mem_req_valid at T+1. With a zero-wait memory, resp at T+1 and the next accept at T+2.
- Back-to-back requests: the next arbitration happens only in IDLE, so each transaction costs at least 2 cycles.
- Requesters may drop req_valid before acceptance; nothing is latched unless ready was high.

Test Plan:
- Single IFU read: ifu_req_valid, addr 0x80000000; mem ready immediately, resp 1 cycle later with 0x00000413 -> ifu_resp_valid pulse at T+2, ifu_rdata = 0x00000413, lsu_resp_valid stays 0.
- Simultaneous requests, starve_cnt = 0: both valid -> lsu_req_ready = 1, ifu_req_ready = 0; mem_addr = lsu_addr, mem_wen/wdata/wmask = LSU values (store 0xDEADBEEF, mask 0xF).
- Starvation, STARVE_LIMIT = 4: both held valid continuously -> grant order LSU, LSU, LSU, LSU, IFU, LSU...
- Backpressure: mem_req_ready low for 3 cycles -> mem_req_valid and all fields stable for those 3 cycles; ready on cycle 4 -> state RESP; busy high throughout.
- Coincident accept and response: mem_req_ready and mem_resp_valid high in the same cycle -> owner resp_valid pulse that cycle; state returns to IDLE with no extra cycle.
- Error and reset: mem_resp_valid pulse in IDLE -> err = 1 and stays 1. rst_n low during RESP -> all outputs 0 immediately; no resp pulse after release; err = 0.
